// File: rtl/mm_result_packer.sv
// mm_result_packer: buffers per-lane systolic results, drains them lane-round-robin,
// packs 32/D_W_ACC results per beat and drives an AXI-stream master with tlast per matrix.
module mm_result_packer #(
  parameter int unsigned M          = 4,
  parameter int unsigned N1         = 4,
  parameter int unsigned D_W_ACC    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N1-1:0]           valid_D,
  input  logic [N1*D_W_ACC-1:0]   data_D,
  output logic [31:0]             m_axis_mm2s_tdata,
  output logic [3:0]              m_axis_mm2s_tkeep,
  output logic                    m_axis_mm2s_tlast,
  output logic                    m_axis_mm2s_tvalid,
  input  logic                    m_axis_mm2s_tready,
  output logic                    overflow,
  output logic                    done
);

  localparam int unsigned PACK   = 32 / D_W_ACC;
  localparam int unsigned MM     = M * M;
  localparam int unsigned BEATS  = MM / PACK;
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LANE_W = (N1 > 1) ? $clog2(N1) : 1;
  localparam int unsigned PCNT_W = $clog2(PACK + 1);
  localparam int unsigned ECNT_W = $clog2(MM + 1);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [N1-1:0]               fifo_empty;
  logic [N1-1:0]               fifo_full;
  logic [N1-1:0]               pop_lane;
  logic [N1-1:0]               push_ok;
  logic [N1-1:0]               drop;
  logic [N1-1:0][D_W_ACC-1:0]  lane_head;
  logic [D_W_ACC-1:0]          head_data;

  logic [LANE_W-1:0]           lane_ptr, lane_ptr_n;
  logic [PCNT_W-1:0]           pack_cnt, pack_cnt_n, slot;
  logic [ECNT_W-1:0]           elem_cnt, elem_cnt_n;
  logic [BEAT_W-1:0]           beat_cnt, beat_cnt_n;
  logic [PACK*D_W_ACC-1:0]     pack_data;
  logic                        tvalid_n, tlast_n;
  logic                        hs, last_hs, xfer, pop;

  // Per-lane circular FIFO with wrap-bit pointers
  for (genvar i = 0; i < N1; i++) begin : g_lane
    logic [D_W_ACC-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W:0]    wptr, rptr;

    assign fifo_empty[i] = (wptr == rptr);
    assign fifo_full[i]  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                           (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign pop_lane[i]   = pop && (lane_ptr == LANE_W'(i));
    assign push_ok[i]    = valid_D[i] && (!fifo_full[i] || pop_lane[i]);
    assign drop[i]       = valid_D[i] && fifo_full[i] && !pop_lane[i];
    assign lane_head[i]  = mem[rptr[ADDR_W-1:0]];

    // Storage array; contents are don't-care until pointed to
    always_ff @(posedge clk) begin
      if (push_ok[i]) begin
        mem[wptr[ADDR_W-1:0]] <= data_D[i*D_W_ACC +: D_W_ACC];
      end
    end

    // Pointer update; a full FIFO accepts a push only when it pops in the same cycle
    always_ff @(posedge clk) begin
      if (rst) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_ok[i])  wptr <= wptr + (ADDR_W+1)'(1);
        if (pop_lane[i]) rptr <= rptr + (ADDR_W+1)'(1);
      end
    end
  end

  assign head_data = lane_head[lane_ptr];

  // Pop/pack/output-transfer decisions and next counter values
  always_comb begin
    hs         = m_axis_mm2s_tvalid && m_axis_mm2s_tready;
    last_hs    = hs && m_axis_mm2s_tlast;
    xfer       = (pack_cnt == PCNT_W'(PACK)) && (!m_axis_mm2s_tvalid || hs);
    pop        = !fifo_empty[lane_ptr] && ((pack_cnt != PCNT_W'(PACK)) || xfer) &&
                 (elem_cnt != ECNT_W'(MM));
    slot       = xfer ? '0 : pack_cnt;
    lane_ptr_n = lane_ptr;
    pack_cnt_n = slot;
    elem_cnt_n = elem_cnt;
    beat_cnt_n = beat_cnt;
    tvalid_n   = m_axis_mm2s_tvalid;

    if (pop) begin
      lane_ptr_n = (lane_ptr == LANE_W'(N1 - 1)) ? '0 : lane_ptr + LANE_W'(1);
      pack_cnt_n = slot + PCNT_W'(1);
      elem_cnt_n = elem_cnt + ECNT_W'(1);
    end

    if (hs) begin
      beat_cnt_n = (beat_cnt == BEAT_W'(BEATS - 1)) ? '0 : beat_cnt + BEAT_W'(1);
      tvalid_n   = 1'b0;
    end
    if (xfer) begin
      tvalid_n = 1'b1;
    end

    // Matrix boundary: every element of this matrix has been popped by now
    if (last_hs) begin
      lane_ptr_n = '0;
      pack_cnt_n = '0;
      elem_cnt_n = '0;
      beat_cnt_n = '0;
    end

    tlast_n = tvalid_n && (beat_cnt_n == BEAT_W'(BEATS - 1));
  end

  // Counter, pack and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_ptr           <= '0;
      pack_cnt           <= '0;
      elem_cnt           <= '0;
      beat_cnt           <= '0;
      pack_data          <= '0;
      m_axis_mm2s_tdata  <= '0;
      m_axis_mm2s_tkeep  <= '0;
      m_axis_mm2s_tlast  <= 1'b0;
      m_axis_mm2s_tvalid <= 1'b0;
      overflow           <= 1'b0;
      done               <= 1'b0;
    end else begin
      lane_ptr           <= lane_ptr_n;
      pack_cnt           <= pack_cnt_n;
      elem_cnt           <= elem_cnt_n;
      beat_cnt           <= beat_cnt_n;
      for (int k = 0; k < int'(PACK); k++) begin
        if (pop && (slot == PCNT_W'(k))) begin
          pack_data[k*D_W_ACC +: D_W_ACC] <= head_data;
        end
      end
      if (xfer) begin
        m_axis_mm2s_tdata <= pack_data;
      end
      m_axis_mm2s_tkeep  <= tvalid_n ? 4'hF : 4'h0;
      m_axis_mm2s_tlast  <= tlast_n;
      m_axis_mm2s_tvalid <= tvalid_n;
      overflow           <= overflow | (|drop);
      done               <= last_hs;
    end
  end

endmodule

// File: tb/tb_mm_result_packer.sv
// Testbench for mm_result_packer: table-driven single matrix plus directed multi-cycle scenarios.
module tb_mm_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid_D;
  logic [63:0] data_D;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid, tready;
  logic        overflow, done;

  mm_result_packer dut (
    .clk                (clk),
    .rst                (rst),
    .valid_D            (valid_D),
    .data_D             (data_D),
    .m_axis_mm2s_tdata  (tdata),
    .m_axis_mm2s_tkeep  (tkeep),
    .m_axis_mm2s_tlast  (tlast),
    .m_axis_mm2s_tvalid (tvalid),
    .m_axis_mm2s_tready (tready),
    .overflow           (overflow),
    .done               (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] data;
    logic [31:0] exp_tdata;
    logic        exp_tlast;
  } vec_t;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] got_d[$];
  logic        got_l[$];
  int          n_done;
  int          first_v;
  logic        hold_prev, hold_l, last_hs_prev;
  logic [31:0] hold_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"},   64'(tvalid),   64'd0);
    chk({tag, "_tdata"},    64'(tdata),    64'd0);
    chk({tag, "_tkeep"},    64'(tkeep),    64'd0);
    chk({tag, "_tlast"},    64'(tlast),    64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_done"},     64'(done),     64'd0);
  endtask

  task automatic clear_cap();
    got_d.delete();
    got_l.delete();
    n_done = 0;
  endtask

  // Drive one cycle of inputs, check per-cycle protocol rules, capture accepted beats
  task automatic cycle(input logic [3:0] v, input logic [63:0] d, input logic rdy);
    valid_D = v;
    data_D  = d;
    tready  = rdy;
    chk("tkeep", 64'(tkeep), tvalid ? 64'hF : 64'h0);
    chk("done_timing", 64'(done), 64'(last_hs_prev));
    if (hold_prev) begin
      chk("hold_tvalid", 64'(tvalid), 64'd1);
      chk("hold_tdata",  64'(tdata),  64'(hold_d));
      chk("hold_tlast",  64'(tlast),  64'(hold_l));
    end
    if (!rst && tvalid && tready) begin
      got_d.push_back(tdata);
      got_l.push_back(tlast);
    end
    if (done) n_done++;
    hold_prev    = !rst && tvalid && !tready;
    hold_d       = tdata;
    hold_l       = tlast;
    last_hs_prev = !rst && tvalid && tready && tlast;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_beat(input int base, input int k);
    int e0, e1;
    e0 = 2 * k;
    e1 = 2 * k + 1;
    return {16'(base + 16 * (e1 % 4) + e1 / 4), 16'(base + 16 * (e0 % 4) + e0 / 4)};
  endfunction

  // Standard matrix: lane i result r = base+16*i+r; lane 3 delayed by skew; tready low for a window
  task automatic run_std(input int base, input int skew, input int st_start, input int st_len,
                         input int ncyc, input int stop_after);
    logic [3:0]  v;
    logic [63:0] d;
    logic        rdy;
    int          r;
    first_v = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (stop_after > 0 && got_d.size() >= stop_after) break;
      v = '0;
      d = '0;
      for (int i = 0; i < 4; i++) begin
        r = c - ((i == 3) ? skew : 0);
        if (r >= 0 && r < 4) begin
          v[i] = 1'b1;
          d[i*16 +: 16] = 16'(base + 16 * i + r);
        end
      end
      rdy = !(c >= st_start && c < st_start + st_len);
      if (tvalid && first_v < 0) first_v = c;
      cycle(v, d, rdy);
    end
  endtask

  task automatic check_matrix(input string tag, input int base);
    chk({tag, "_beats"}, 64'(got_d.size()), 64'd8);
    for (int k = 0; k < got_d.size() && k < 8; k++) begin
      chk({tag, "_tdata"}, 64'(got_d[k]), 64'(model_beat(base, k)));
      chk({tag, "_tlast"}, 64'(got_l[k]), 64'(k == 7));
    end
    chk({tag, "_done_cnt"}, 64'(n_done), 64'd1);
  endtask

  vec_t        tbl[8];
  logic [31:0] ovf_exp[8];

  initial begin
    tbl[0] = '{4'hF, 64'h0030_0020_0010_0000, 32'h0010_0000, 1'b0};
    tbl[1] = '{4'hF, 64'h0031_0021_0011_0001, 32'h0030_0020, 1'b0};
    tbl[2] = '{4'hF, 64'h0032_0022_0012_0002, 32'h0011_0001, 1'b0};
    tbl[3] = '{4'hF, 64'h0033_0023_0013_0003, 32'h0031_0021, 1'b0};
    tbl[4] = '{4'h0, 64'h0,                   32'h0012_0002, 1'b0};
    tbl[5] = '{4'h0, 64'h0,                   32'h0032_0022, 1'b0};
    tbl[6] = '{4'h0, 64'h0,                   32'h0013_0003, 1'b0};
    tbl[7] = '{4'h0, 64'h0,                   32'h0033_0023, 1'b1};

    ovf_exp = '{32'h0110_0100, 32'h0130_0120, 32'h0311_00A0, 32'h0331_0321,
                32'h0312_00A1, 32'h0332_0322, 32'h0313_00A2, 32'h0333_0323};

    hold_prev    = 1'b0;
    last_hs_prev = 1'b0;
    hold_d       = '0;
    hold_l       = 1'b0;
    n_done       = 0;

    // Reset held with all lanes strobing junk
    rst     = 1'b1;
    valid_D = 4'hF;
    data_D  = 64'hDEAD_BEEF_DEAD_BEEF;
    tready  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_zero("reset");
    end
    rst = 1'b0;

    // Single matrix from the vector table
    clear_cap();
    first_v = -1;
    for (int k = 0; k < 8; k++) begin
      if (tvalid && first_v < 0) first_v = k;
      cycle(tbl[k].valid, tbl[k].data, 1'b1);
    end
    for (int c = 0; c < 40; c++) cycle(4'h0, 64'h0, 1'b1);
    chk("tbl_latency", 64'(first_v), 64'd4);
    chk("tbl_beats", 64'(got_d.size()), 64'd8);
    for (int k = 0; k < 8 && k < got_d.size(); k++) begin
      chk("tbl_tdata", 64'(got_d[k]), 64'(tbl[k].exp_tdata));
      chk("tbl_tlast", 64'(got_l[k]), 64'(tbl[k].exp_tlast));
    end
    chk("tbl_done_cnt", 64'(n_done), 64'd1);
    chk("tbl_overflow", 64'(overflow), 64'd0);

    // Backpressure: 20 cycles of tready low mid-matrix
    clear_cap();
    run_std(32'h100, 0, 5, 20, 80, 0);
    check_matrix("bp", 32'h100);
    chk("bp_overflow", 64'(overflow), 64'd0);

    // Skew: lane 3 six cycles late
    clear_cap();
    run_std(32'h200, 6, 1000, 0, 80, 0);
    check_matrix("skew", 32'h200);
    chk("skew_overflow", 64'(overflow), 64'd0);

    // Overflow: fill output and pack register, then 5 pushes on lane 0 with tready low
    clear_cap();
    cycle(4'hF, 64'h0130_0120_0110_0100, 1'b0);
    for (int c = 0; c < 6; c++) cycle(4'h0, 64'h0, 1'b0);
    chk("ovf_prefill_tvalid", 64'(tvalid), 64'd1);
    chk("ovf_prefill_tdata",  64'(tdata),  64'h0110_0100);
    for (int a = 0; a < 5; a++) begin
      if (a == 4) chk("ovf_before", 64'(overflow), 64'd0);
      cycle(4'h1, 64'(16'(16'h00A0 + a)), 1'b0);
    end
    chk("ovf_after", 64'(overflow), 64'd1);
    for (int r = 1; r < 4; r++) begin
      cycle(4'hE, {16'(16'h0330 + r), 16'(16'h0320 + r), 16'(16'h0310 + r), 16'h0}, 1'b1);
    end
    for (int c = 0; c < 40; c++) cycle(4'h0, 64'h0, 1'b1);
    chk("ovf_beats", 64'(got_d.size()), 64'd8);
    for (int k = 0; k < 8 && k < got_d.size(); k++) begin
      chk("ovf_tdata", 64'(got_d[k]), 64'(ovf_exp[k]));
      chk("ovf_tlast", 64'(got_l[k]), 64'(k == 7));
    end
    chk("ovf_done_cnt", 64'(n_done), 64'd1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Leftover A3 heads the next matrix; the dropped A4 must not appear
    clear_cap();
    for (int r = 0; r < 2; r++) begin
      cycle(4'hE, {16'(16'h0430 + r), 16'(16'h0420 + r), 16'(16'h0410 + r), 16'h0}, 1'b1);
    end
    for (int c = 0; c < 30; c++) cycle(4'h0, 64'h0, 1'b1);
    chk("drop_beats", 64'(got_d.size()), 64'd2);
    if (got_d.size() >= 2) begin
      chk("drop_beat0", 64'(got_d[0]), 64'h0410_00A3);
      chk("drop_beat1", 64'(got_d[1]), 64'h0430_0420);
    end
    chk("drop_idle", 64'(tvalid), 64'd0);

    // Reset clears the stuck partial matrix and the sticky flag
    rst = 1'b1;
    cycle(4'h0, 64'h0, 1'b1);
    cycle(4'h0, 64'h0, 1'b1);
    chk_zero("rst2");
    rst = 1'b0;

    // Reset mid-matrix after 3 beats, then one full matrix
    clear_cap();
    run_std(32'h500, 0, 1000, 0, 80, 3);
    chk("mid_pre_beats", 64'(got_d.size()), 64'd3);
    rst = 1'b1;
    cycle(4'h0, 64'h0, 1'b1);
    cycle(4'h0, 64'h0, 1'b1);
    chk_zero("rst3");
    rst = 1'b0;
    clear_cap();
    run_std(32'h600, 0, 1000, 0, 80, 0);
    check_matrix("mid", 32'h600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
